// File: rtl/dual_mode_queue_pkg.sv
// Shared types and helpers for the dual-mode (FIFO/LIFO) queue.
package queue_pkg;

  typedef enum logic {
    QMODE_FIFO = 1'b0,
    QMODE_LIFO = 1'b1
  } qmode_t;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dual_mode_queue_mem.sv
// Storage array for the queue: one synchronous write port, one
// asynchronous read port, no reset on the contents.
module queue_mem
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 256,
  localparam int AW        = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted enqueue.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dual_mode_queue.sv
// Single-clock buffer replaying stored symbols in arrival (FIFO) or
// reverse (LIFO) order, with registered read port and error pulses.
module dual_mode_queue
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     enqueue,
  input  logic                     dequeue,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     out_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]         head, tail, tail_m1;
  logic [PW-1:0]         wr_addr, rd_addr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] rd_data;
  qmode_t                mode_q;
  logic                  deq_acc, enq_acc, mode_load, lifo;

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);

  // A dequeue needs data; an enqueue needs room, or a slot freed this cycle.
  assign deq_acc   = dequeue & ~empty;
  assign enq_acc   = enqueue & (~full | deq_acc);
  // Mode only changes while drained and nothing is arriving.
  assign mode_load = empty & ~enqueue;
  assign lifo      = (mode_q == QMODE_LIFO);

  assign tail_m1 = tail - PW'(1);
  // LIFO reads the top of stack; a LIFO push+pop overwrites that same top.
  assign rd_addr = lifo ? tail_m1 : head;
  assign wr_addr = (lifo && deq_acc) ? tail_m1 : tail;

  queue_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (enq_acc),
    .wr_addr(wr_addr),
    .wr_data(data_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Mode register and pointers; loading a mode restarts both pointers at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= QMODE_FIFO;
      head   <= '0;
      tail   <= '0;
    end else if (mode_load) begin
      mode_q <= qmode_t'(mode);
      head   <= '0;
      tail   <= '0;
    end else if (!lifo) begin
      if (enq_acc) tail <= tail + PW'(1);
      if (deq_acc) head <= head + PW'(1);
    end else begin
      if (enq_acc && !deq_acc)      tail <= tail + PW'(1);
      else if (deq_acc && !enq_acc) tail <= tail_m1;
    end
  end

  // Occupancy: moves by one, unchanged when push and pop coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   count_q <= '0;
    else if (enq_acc && !deq_acc) count_q <= count_q + CW'(1);
    else if (deq_acc && !enq_acc) count_q <= count_q - CW'(1);
  end

  // Registered read port and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (deq_acc) data_out <= rd_data;
      out_valid <= deq_acc;
      overflow  <= enqueue & ~enq_acc;
      underflow <= dequeue & ~deq_acc;
    end
  end

endmodule
